// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between producers, the round-robin arbiter and the async FIFO write side.
// master: producer/FIFO side that drives requests and full; slave: the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int STALL_W = 16
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_in;
  logic                     grant_valid;
  logic [IDW-1:0]           grant_id;
  logic [STALL_W-1:0]       stall_cnt;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_in, grant_valid, grant_id, stall_cnt
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_in, grant_valid, grant_id, stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST beats; a full FIFO stalls the burst but never releases it.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int STALL_W   = 16
) (
  input  logic              wr_clk,
  input  logic              wr_reset_n,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW = $clog2(MAX_BURST) + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state, w_state_next;
  logic [IDW-1:0]     r_grant_id, w_grant_id_next;
  logic [IDW-1:0]     r_rr_ptr, w_rr_ptr_next;
  logic [BCW-1:0]     r_beat_cnt, w_beat_cnt_next;
  logic [STALL_W-1:0] r_stall_cnt;

  logic [WIDTH-1:0] w_data [NUM_REQ];
  logic             w_granted;
  logic             w_any_valid;
  logic             w_beat;
  logic             w_stall;
  logic             w_release;
  logic [IDW-1:0]   w_scan_base;
  logic [IDW-1:0]   w_pick;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  // First valid index after base, wrapping, so base itself is scanned last.
  function automatic logic [IDW-1:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IDW-1:0]     base);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_granted   = (r_state == S_GRANT);
  assign w_any_valid = |bus.req_valid;
  assign w_beat      = w_granted && bus.req_valid[r_grant_id] && !bus.fifo_full;
  assign w_stall     = w_granted && bus.req_valid[r_grant_id] && bus.fifo_full;
  assign w_release   = w_granted &&
                       ((w_beat && (r_beat_cnt == BCW'(MAX_BURST - 1))) ||
                        !bus.req_valid[r_grant_id]);
  // On release the outgoing grant becomes the new round-robin pointer.
  assign w_scan_base = w_granted ? r_grant_id : r_rr_ptr;
  assign w_pick      = f_pick(bus.req_valid, w_scan_base);

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_grant_id  <= '0;
      r_rr_ptr    <= IDW'(NUM_REQ - 1);
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_grant_id <= w_grant_id_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_beat_cnt <= w_beat_cnt_next;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_id_next = r_grant_id;
    w_rr_ptr_next   = r_rr_ptr;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_next    = S_GRANT;
          w_grant_id_next = w_pick;
          w_beat_cnt_next = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_rr_ptr_next   = r_grant_id;
          w_beat_cnt_next = '0;
          if (w_any_valid) begin
            w_grant_id_next = w_pick;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_beat) begin
          w_beat_cnt_next = r_beat_cnt + BCW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.grant_valid = w_granted;
    bus.grant_id    = r_grant_id;
    bus.stall_cnt   = r_stall_cnt;
    bus.fifo_wr_en  = w_beat;
    bus.fifo_in     = w_granted ? w_data[r_grant_id] : '0;
    bus.req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = w_granted && (r_grant_id == IDW'(i)) && !bus.fifo_full;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, bursts, round-robin order, stalls,
// early release, asynchronous reset mid-burst and stall counter saturation.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
  localparam int STALL_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .STALL_W(STALL_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .STALL_W(STALL_W)
  ) dut (
    .wr_clk(clk),
    .wr_reset_n(rst_n),
    .bus(bus)
  );

  task automatic set_data(input int idx, input logic [WIDTH-1:0] v);
    bus.req_data[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h44332211;
    bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL rst_grant_valid: got %b expected 0", bus.grant_valid); end
    vectors++; if (bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant_id: got %0d expected 0", bus.grant_id); end
    vectors++; if (bus.stall_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_stall_cnt: got %h expected 0000", bus.stall_cnt); end
    vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b expected 0", bus.fifo_wr_en); end
    vectors++; if (bus.fifo_in !== 8'h00) begin miscompares++; $display("FAIL rst_fifo_in: got %h expected 00", bus.fifo_in); end
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
    $display("reset: outputs idle while held in reset");
  endtask

  task automatic test_single_burst();
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0001;
    set_data(0, 8'hA0);
    #1;
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency_gv: got %b expected 0", bus.grant_valid); end
    vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_latency_wr: got %b expected 0", bus.fifo_wr_en); end
    for (int k = 0; k < MAX_BURST; k++) begin
      @(negedge clk);
      set_data(0, 8'(8'hA0 + k));
      #1;
      vectors++; if (bus.grant_valid !== 1'b1) begin miscompares++; $display("FAIL single_gv beat %0d: got %b expected 1", k, bus.grant_valid); end
      vectors++; if (bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL single_id beat %0d: got %0d expected 0", k, bus.grant_id); end
      vectors++; if (bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr beat %0d: got %b expected 1", k, bus.fifo_wr_en); end
      vectors++; if (bus.fifo_in !== 8'(8'hA0 + k)) begin miscompares++; $display("FAIL single_data beat %0d: got %h expected %h", k, bus.fifo_in, 8'(8'hA0 + k)); end
      vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready beat %0d: got %b expected 0001", k, bus.req_ready); end
      $display("single: beat %0d data %h", k, bus.fifo_in);
    end
    @(negedge clk);
    set_data(0, 8'hB0);
    #1;
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL single_regrant: got gv=%b id=%0d expected gv=1 id=0", bus.grant_valid, bus.grant_id); end
    vectors++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_in !== 8'hB0) begin miscompares++; $display("FAIL single_regrant_beat: got wr=%b data=%h expected wr=1 data=b0", bus.fifo_wr_en, bus.fifo_in); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_drop_wr: got %b expected 0", bus.fifo_wr_en); end
    @(negedge clk);
    #1;
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b expected 0", bus.grant_valid); end
    $display("single: regrant without bubble, idle after valid drop");
  endtask

  task automatic test_round_robin();
    int exp_id;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(16 * (i + 1)));
    @(negedge clk);
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % NUM_REQ;
      for (int b = 0; b < MAX_BURST; b++) begin
        @(negedge clk);
        #1;
        vectors++; if (bus.grant_valid !== 1'b1) begin miscompares++; $display("FAIL rr_gv g%0d b%0d: got %b expected 1", g, b, bus.grant_valid); end
        vectors++; if (bus.grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL rr_id g%0d b%0d: got %0d expected %0d", g, b, bus.grant_id, exp_id); end
        vectors++; if (bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL rr_wr g%0d b%0d: got %b expected 1", g, b, bus.fifo_wr_en); end
        vectors++; if (bus.fifo_in !== 8'(16 * (exp_id + 1))) begin miscompares++; $display("FAIL rr_data g%0d b%0d: got %h expected %h", g, b, bus.fifo_in, 8'(16 * (exp_id + 1))); end
        vectors++; if (bus.req_ready !== 4'(1 << exp_id)) begin miscompares++; $display("FAIL rr_ready g%0d b%0d: got %b expected %b", g, b, bus.req_ready, 4'(1 << exp_id)); end
      end
      $display("round_robin: grant %0d to requester %0d", g, bus.grant_id);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_full_stall();
    do_reset();
    set_data(2, 8'h2C);
    set_data(3, 8'h3C);
    @(negedge clk);
    bus.req_valid = 4'b1100;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      #1;
      vectors++; if (bus.grant_id !== 2'd2 || bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL stall_pre b%0d: got id=%0d wr=%b expected id=2 wr=1", b, bus.grant_id, bus.fifo_wr_en); end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.fifo_full = 1'b1;
      #1;
      vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL stall_wr c%0d: got %b expected 0", c, bus.fifo_wr_en); end
      vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL stall_ready c%0d: got %b expected 0000", c, bus.req_ready); end
      vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2) begin miscompares++; $display("FAIL stall_hold c%0d: got gv=%b id=%0d expected gv=1 id=2", c, bus.grant_valid, bus.grant_id); end
    end
    @(negedge clk);
    bus.fifo_full = 1'b0;
    #1;
    vectors++; if (bus.stall_cnt !== 16'd5) begin miscompares++; $display("FAIL stall_cnt: got %0d expected 5", bus.stall_cnt); end
    vectors++; if (bus.grant_id !== 2'd2 || bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL stall_resume3: got id=%0d wr=%b expected id=2 wr=1", bus.grant_id, bus.fifo_wr_en); end
    @(negedge clk);
    #1;
    vectors++; if (bus.grant_id !== 2'd2 || bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL stall_resume4: got id=%0d wr=%b expected id=2 wr=1", bus.grant_id, bus.fifo_wr_en); end
    @(negedge clk);
    #1;
    vectors++; if (bus.grant_id !== 2'd3 || bus.fifo_in !== 8'h3C) begin miscompares++; $display("FAIL stall_next: got id=%0d data=%h expected id=3 data=3c", bus.grant_id, bus.fifo_in); end
    $display("full_stall: stall_cnt %0d, next grant %0d", bus.stall_cnt, bus.grant_id);
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_early_release();
    do_reset();
    set_data(0, 8'h0D);
    set_data(1, 8'h1D);
    set_data(3, 8'h3D);
    @(negedge clk);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = 4'b1011;
    #1;
    vectors++; if (bus.grant_id !== 2'd1 || bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL early_b1: got id=%0d wr=%b expected id=1 wr=1", bus.grant_id, bus.fifo_wr_en); end
    @(negedge clk);
    #1;
    vectors++; if (bus.grant_id !== 2'd1 || bus.fifo_in !== 8'h1D) begin miscompares++; $display("FAIL early_b2: got id=%0d data=%h expected id=1 data=1d", bus.grant_id, bus.fifo_in); end
    @(negedge clk);
    bus.req_valid = 4'b1001;
    #1;
    vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL early_nobeat: got %b expected 0", bus.fifo_wr_en); end
    vectors++; if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL early_ready: got %b expected 0010", bus.req_ready); end
    @(negedge clk);
    #1;
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3) begin miscompares++; $display("FAIL early_next: got gv=%b id=%0d expected gv=1 id=3", bus.grant_valid, bus.grant_id); end
    vectors++; if (bus.fifo_in !== 8'h3D || bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL early_next_beat: got data=%h wr=%b expected data=3d wr=1", bus.fifo_in, bus.fifo_wr_en); end
    $display("early_release: requester 1 released, next grant %0d", bus.grant_id);
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_data(1, 8'h1E);
    set_data(2, 8'h2E);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.grant_id !== 2'd2 || bus.fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: got id=%0d wr=%b expected id=2 wr=1", bus.grant_id, bus.fifo_wr_en); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL midrst_grant: got gv=%b id=%0d expected gv=0 id=0", bus.grant_valid, bus.grant_id); end
    vectors++; if (bus.fifo_wr_en !== 1'b0 || bus.fifo_in !== 8'h00) begin miscompares++; $display("FAIL midrst_fifo: got wr=%b data=%h expected wr=0 data=00", bus.fifo_wr_en, bus.fifo_in); end
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL midrst_ready: got %b expected 0000", bus.req_ready); end
    bus.req_valid = 4'b1010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.grant_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got %b expected 0", bus.grant_valid); end
    @(negedge clk);
    #1;
    vectors++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) begin miscompares++; $display("FAIL midrst_first: got gv=%b id=%0d expected gv=1 id=1", bus.grant_valid, bus.grant_id); end
    $display("reset_mid_burst: first grant after reset %0d", bus.grant_id);
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_stall_saturation();
    do_reset();
    set_data(0, 8'h5A);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.fifo_full = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (bus.stall_cnt !== 16'h0000 || bus.grant_valid !== 1'b1) begin miscompares++; $display("FAIL sat_start: got cnt=%h gv=%b expected cnt=0000 gv=1", bus.stall_cnt, bus.grant_valid); end
    repeat (65534) @(negedge clk);
    #1;
    vectors++; if (bus.stall_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_fffe: got %h expected fffe", bus.stall_cnt); end
    @(negedge clk);
    #1;
    vectors++; if (bus.stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_ffff: got %h expected ffff", bus.stall_cnt); end
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h expected ffff", bus.stall_cnt); end
    vectors++; if (bus.fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL sat_wr: got %b expected 0", bus.fifo_wr_en); end
    @(negedge clk);
    bus.fifo_full = 1'b0;
    #1;
    vectors++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_in !== 8'h5A) begin miscompares++; $display("FAIL sat_resume: got wr=%b data=%h expected wr=1 data=5a", bus.fifo_wr_en, bus.fifo_in); end
    $display("stall_saturation: stall_cnt %h", bus.stall_cnt);
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_stall_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
